// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Shared op codes, widths and response-entry helpers for the ALU responder.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_NOTA = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_SHL  = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_SHR  = 3'd7;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_TAG_W = 4;

  // Entry layout, MSB first: {tag, zero, carry, y}
  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic                 zero;
    logic                 carry;
    logic [DEF_WIDTH-1:0] y;
  } alu_rsp_t;

  function automatic int rsp_entry_w(input int width, input int tag_w);
    return width + tag_w + 2;
  endfunction

endpackage

// File: rtl/alu_req_responder_if.sv
// rtl/alu_req_responder_if.sv - Request/response handshake bundle between an initiator and the ALU responder.
interface alu_req_responder_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [ALU_OP_W-1:0] req_op;
  logic [WIDTH-1:0]    req_a;
  logic [WIDTH-1:0]    req_b;
  logic [TAG_W-1:0]    req_tag;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_y;
  logic                rsp_carry;
  logic                rsp_zero;
  logic [TAG_W-1:0]    rsp_tag;

  logic [15:0]         op_count;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_tag, op_count
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_carry, rsp_zero, rsp_tag, op_count
  );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - Combinational 8-function ALU with carry/zero; ALU_RESP_SAT_EN makes ADD/SUB saturate.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  output logic [WIDTH-1:0]    y_o,
  output logic                carry_o,
  output logic                zero_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Extra MSB carries the carry-out for ADD and the borrow for SUB
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    y_o     = '0;
    carry_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        y_o     = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
`ifdef ALU_RESP_SAT_EN
        if (sum[WIDTH]) y_o = '1;
`endif
      end
      OP_SUB: begin
        y_o     = diff[WIDTH-1:0];
        carry_o = diff[WIDTH];
`ifdef ALU_RESP_SAT_EN
        if (diff[WIDTH]) y_o = '0;
`endif
      end
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOTA: y_o = ~a_i;
      OP_SHL: begin
        y_o     = {a_i[WIDTH-2:0], 1'b0};
        carry_o = a_i[WIDTH-1];
      end
      OP_SHR: begin
        y_o     = {1'b0, a_i[WIDTH-1:1]};
        carry_o = a_i[0];
      end
      default: begin
        y_o     = '0;
        carry_o = 1'b0;
      end
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/alu_req_responder.sv
// rtl/alu_req_responder.sv - ALU responder: handshaked request in, in-order DEPTH-entry response FIFO out.
// Optional ADD/SUB saturation is selected by ALU_RESP_SAT_EN inside alu_core.
module alu_req_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst,
  alu_req_responder_if.slave bus
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = rsp_entry_w(WIDTH, TAG_W);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [15:0]        op_count_q, op_count_d;

  logic [WIDTH-1:0]   alu_y;
  logic               alu_carry;
  logic               alu_zero;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op_i    (bus.req_op),
    .a_i     (bus.req_a),
    .b_i     (bus.req_b),
    .y_o     (alu_y),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  // Ready depends only on the registered count, so a pop never frees a full FIFO in the same cycle
  assign bus.req_ready = (count_q < DEPTH_C);
  assign bus.rsp_valid = (count_q != '0);
  assign push          = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign head = mem_q[rd_ptr_q];
  assign {bus.rsp_tag, bus.rsp_zero, bus.rsp_carry, bus.rsp_y} = head;
  assign bus.op_count = op_count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_count_d = op_count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      op_count_d = op_count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads as zero until the first push
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
      if (push) mem_q[wr_ptr_q] <= {bus.req_tag, alu_zero, alu_carry, alu_y};
    end
  end

endmodule

// File: doc/alu_req_responder.md
Name: alu_req_responder

Overview:
- Responder side of the ALU request interface: accepts {op, a, b, tag} requests under a valid/ready handshake.
- Computes the 8-function ALU result with carry/zero flags and returns it, in order, through a DEPTH-entry response FIFO under a second valid/ready handshake.
- Sits between any stimulus/initiator block and downstream consumers.
- Replaces direct combinational ALU use wherever backpressure or registered outputs are needed.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- DEPTH, 2, response FIFO entries (power of 2, ≥2).
- TAG_W, 4, width of the request tag echoed on the response.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_op  in  3  function select (encoding below).
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_tag  in  TAG_W  initiator tag, echoed unchanged.
- rsp_valid  out  1  response present at FIFO head.
- rsp_ready  in  1  consumer accepts response.
- rsp_y  out  WIDTH  result.
- rsp_carry  out  1  carry/borrow/shift-out flag.
- rsp_zero  out  1  result == 0.
- rsp_tag  out  TAG_W  echoed tag.
- op_count  out  16  responses delivered since reset; wraps 0xFFFF→0.

Behaviour:
- Op encoding:
  - 000 ADD: y = a+b; carry = carry-out.
  - 001 SUB: y = a−b mod 2^WIDTH; carry = borrow (a<b unsigned).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 NOTA: y = ~a; carry = 0.
  - 110 SHL: y = a<<1; carry = a[WIDTH-1].
  - 111 SHR (logical): y = a>>1; carry = a[0].
- Zero flag: rsp_zero = (y == 0) for every op.
- Accept: a request is accepted on a rising edge with req_valid && req_ready. The result is computed combinationally from the request fields and written into the FIFO at the same edge.
- req_ready = (fifo_count < DEPTH). It has no combinational path from rsp_ready. When full, req_ready is 0 even if a pop occurs that cycle.
- Response: rsp_valid = (fifo_count != 0). rsp_y/rsp_carry/rsp_zero/rsp_tag present the FIFO head. The head is popped on an edge with rsp_valid && rsp_ready.
- Latency: a request accepted at edge N with the FIFO empty gives rsp_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 response per cycle when rsp_ready is held high.
- Ordering: strictly in acceptance order.
- Stability: while rsp_valid && !rsp_ready, all rsp_* outputs hold constant.
- Simultaneous push and pop (count between 1 and DEPTH−1): count is unchanged, the head advances, and the new entry is appended.
- Empty: pop is impossible; rsp_* data outputs show the last head and are don't-care.
- Full: req_ready=0 and no push occurs, regardless of req_valid.
- op_count increments by 1 on each pop edge.
- Reset (any cycle, including mid-stream):
  - fifo_count=0, read/write pointers=0.
  - rsp_valid=0, req_ready=1 in the cycle after reset.
  - rsp_y, rsp_carry, rsp_zero, rsp_tag = 0; op_count = 0.
  - In-flight entries are discarded; a request presented in the reset cycle is not accepted.

Optional Feature:
- Macro: ALU_RESP_SAT_EN.
- Defined: ADD saturates to all-ones when carry-out=1, and SUB saturates to 0 when borrow=1. rsp_carry still reports the raw carry/borrow, and rsp_zero reflects the saturated y.
- Undefined: ADD/SUB wrap modulo 2^WIDTH as above.
- All other ops are unaffected either way.

Decomposition:
- Shared package alu_pkg:
  - Op localparams OP_ADD..OP_SHR (3-bit).
  - ALU_OP_W = 3.
  - Response struct/typedef {y, carry, zero, tag} packed width helper.
- Sub-module alu_core: purely combinational (op, a, b) → (y, carry, zero), WIDTH-parameterised, with ALU_RESP_SAT_EN applied inside it.
- The top level owns the FIFO, handshake, pointers and op_count.

Test Plan:
- Reset, then a=8'h0F, b=8'h01, op=000, rsp_ready=1 → one cycle later rsp_valid=1, y=8'h10, carry=0, zero=0, tag echoed, op_count=1 after pop.
- ADD a=8'hFF, b=8'h01 → y=8'h00, carry=1, zero=1. With ALU_RESP_SAT_EN: y=8'hFF, carry=1, zero=0. Also SUB a=8'h03, b=8'h05 → y=8'hFE (sat: 8'h00), carry=1.
- rsp_ready=0, issue three requests with tags 1,2,3 back-to-back:
  - Tags 1 and 2 are accepted.
  - req_ready drops after the 2nd accept; tag 3 waits.
  - rsp_* stay stable on tag 1.
  - Raising rsp_ready delivers tags 1,2,3 in order.
- Shifts: SHL a=8'h81 → y=8'h02, carry=1. SHR a=8'h81 → y=8'h40, carry=1. NOTA a=8'hFF → y=0, zero=1.
- Continuous stream of 10 ADD/XOR requests with rsp_ready=1 → one response per cycle, req_ready never deasserts, op_count=10.
- Assert rst for one cycle with 2 entries queued → next cycle rsp_valid=0, req_ready=1, op_count=0, rsp_y=0, and no stale response ever appears.
